alu_issue_stage: RTL

- Issue and write-back stage wrapped around the combinational ALU16bit in microcpu.
- Holds a small 16-bit register file and accepts one instruction at a time on a valid/ready handshake.
- Reads rs/rt (or an immediate), drives the registered a/b/func inputs of ALU16bit, captures the ALU output and writes it into rd.
- Also provides an external preload port and a debug read port.

---
 rtl/microcpu_pkg.sv | 28 ++
 rtl/alu_regfile.sv | 51 +++++
 rtl/alu_issue_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/microcpu_pkg.sv
// Shared definitions for the microcpu ALU issue stage: default sizes,
// ALU function codes and the issue FSM state type.
package microcpu_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 4;
    localparam int DEF_RAW   = 2;

    // Function codes understood by ALU16bit; the issue stage only treats NOP specially.
    localparam logic [3:0] FUNC_NOP = 4'd0;
    localparam logic [3:0] FUNC_ADD = 4'd1;
    localparam logic [3:0] FUNC_SUB = 4'd2;
    localparam logic [3:0] FUNC_AND = 4'd3;
    localparam logic [3:0] FUNC_OR  = 4'd4;
    localparam logic [3:0] FUNC_XOR = 4'd5;
    localparam logic [3:0] FUNC_SHL = 4'd6;
    localparam logic [3:0] FUNC_SHR = 4'd7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } issue_state_e;

    function automatic logic is_nop(input logic [3:0] func);
        return (func == FUNC_NOP);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file for the ALU issue stage: one write port, two
// instruction read ports and one debug read port, all reads combinational.
module alu_regfile
    import microcpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int RAW   = DEF_RAW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [RAW-1:0]   waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [RAW-1:0]   ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [RAW-1:0]   rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic [RAW-1:0]   dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic [WIDTH-1:0] mem_d [NREGS];

    // Next-state of the storage array: at most one entry changes per cycle.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign ra_data  = mem_q[ra_addr];
    assign rb_data  = mem_q[rb_addr];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/write-back stage around ALU16bit: accepts one instruction per two
// cycles, drives registered ALU operands and writes the result back to rd.
module alu_issue_stage
    import microcpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int RAW   = DEF_RAW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_func,
    input  logic [RAW-1:0]   instr_rd,
    input  logic [RAW-1:0]   instr_rs,
    input  logic [RAW-1:0]   instr_rt,
    input  logic             instr_use_imm,
    input  logic [WIDTH-1:0] instr_imm,
    input  logic             ld_en,
    input  logic [RAW-1:0]   ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_func,
    input  logic [WIDTH-1:0] alu_out,
    output logic             done,
    output logic [RAW-1:0]   done_rd,
    output logic [WIDTH-1:0] done_data,
    input  logic [RAW-1:0]   dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    issue_state_e     state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_func_q, alu_func_d;
    logic [RAW-1:0]   rd_q, rd_d;
    logic             nop_q, nop_d;
    logic             done_q, done_d;
    logic [RAW-1:0]   done_rd_q, done_rd_d;
    logic [WIDTH-1:0] done_data_q, done_data_d;

    logic             rf_we_s;
    logic [RAW-1:0]   rf_waddr_s;
    logic [WIDTH-1:0] rf_wdata_s;
    logic [WIDTH-1:0] rs_data_s;
    logic [WIDTH-1:0] rt_data_s;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .RAW   (RAW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we_s),
        .waddr    (rf_waddr_s),
        .wdata    (rf_wdata_s),
        .ra_addr  (instr_rs),
        .ra_data  (rs_data_s),
        .rb_addr  (instr_rt),
        .rb_data  (rt_data_s),
        .dbg_addr (dbg_sel),
        .dbg_data (dbg_data)
    );

    // Issue FSM: preload has priority over issue; EXEC always retires in one cycle.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_func_d  = alu_func_q;
        rd_d        = rd_q;
        nop_d       = nop_q;
        done_d      = 1'b0;
        done_rd_d   = done_rd_q;
        done_data_d = done_data_q;
        rf_we_s     = 1'b0;
        rf_waddr_s  = {RAW{1'b0}};
        rf_wdata_s  = {WIDTH{1'b0}};
        case (state_q)
            IDLE: begin
                if (ld_en) begin
                    rf_we_s    = 1'b1;
                    rf_waddr_s = ld_addr;
                    rf_wdata_s = ld_data;
                end else if (instr_valid) begin
                    alu_a_d    = rs_data_s;
                    alu_b_d    = instr_use_imm ? instr_imm : rt_data_s;
                    alu_func_d = instr_func;
                    rd_d       = instr_rd;
                    nop_d      = is_nop(instr_func);
                    state_d    = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                // Any ld_en seen here is intentionally dropped.
                if (!nop_q) begin
                    rf_we_s    = 1'b1;
                    rf_waddr_s = rd_q;
                    rf_wdata_s = alu_out;
                end else begin
                    rf_we_s = 1'b0;
                end
                done_d      = 1'b1;
                done_rd_d   = rd_q;
                done_data_d = alu_out;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_a_q     <= {WIDTH{1'b0}};
            alu_b_q     <= {WIDTH{1'b0}};
            alu_func_q  <= 4'd0;
            rd_q        <= {RAW{1'b0}};
            nop_q       <= 1'b0;
            done_q      <= 1'b0;
            done_rd_q   <= {RAW{1'b0}};
            done_data_q <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_func_q  <= alu_func_d;
            rd_q        <= rd_d;
            nop_q       <= nop_d;
            done_q      <= done_d;
            done_rd_q   <= done_rd_d;
            done_data_q <= done_data_d;
        end
    end

    assign instr_ready = (state_q == IDLE) && !ld_en && !rst;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_func    = alu_func_q;
    assign done        = done_q;
    assign done_rd     = done_rd_q;
    assign done_data   = done_data_q;

endmodule
